inst_queue: RTL
===============

// Module: inst_queue
// PURPOSE
//  Dual-write / dual-read circular instruction queue between IF and ID. Accepts up to two
//  fetched instructions (with PCs) per cycle from the 64-bit ICache return, and presents the
//  two oldest entries to the ID issue logic, which pops one (single issue) or two (dual issue).
//  Absorbs fetch/issue rate mismatch; cleared on exception flush or taken branch.
// PARAMETERS
//  DEPTH        32  entries; power of two, >= 8
//  AW           5   pointer width, = log2(DEPTH)
//  FULL_MARGIN  4   buffer_full_o asserts when free slots <= FULL_MARGIN (covers IF latency)
// PORTS
//  clk              in   1   clock; all state on posedge
//  rst              in   1   synchronous, active-high reset
//  flush            in   1   clear queue (exception flush or taken branch)
//  push_inst1_i     in   32  older fetched instruction
//  push_inst2_i     in   32  younger fetched instruction
//  push_pc1_i       in   32  PC of push_inst1_i
//  push_pc2_i       in   32  PC of push_inst2_i
//  push_valid1_i    in   1   push_inst1_i valid
//  push_valid2_i    in   1   push_inst2_i valid
//  issue_i          in   1   ID consumes entries this cycle
//  issue_mode_i     in   1   0 = `SingleIssue (pop 1), 1 = `DualIssue (pop 2)
//  issue_inst1_o    out  32  entry at head (0 if count==0)
//  issue_inst2_o    out  32  entry at head+1 (0 if count<2)
//  issue_pc1_o      out  32  PC of head entry (0 if count==0)
//  issue_pc2_o      out  32  PC of head+1 entry (0 if count<2)
//  issue_ok_o       out  1   count >= 1
//  issue_dual_ok_o  out  1   count >= 2
//  buffer_full_o    out  1   (DEPTH - count) <= FULL_MARGIN
// BEHAVIOUR
//  - State: head, tail (AW bits, wrap modulo DEPTH), count (AW+1 bits), storage {inst,pc}xDEPTH.
//  - Reset/flush (rst has priority, then flush): head=tail=count=0 next cycle; same-cycle push and
//    pop ignored. Outputs after reset: all data 0, issue_ok_o=0, issue_dual_ok_o=0, buffer_full_o=0.
//  - Push compaction: both valid -> inst1 at tail, inst2 at tail+1, tail+=2; exactly one valid ->
//    written at tail, tail+=1; none -> no write.
//  - Overflow guard: push of n entries accepted only if count_at_cycle_start + n <= DEPTH
//    (pops in same cycle not credited); otherwise whole push dropped. Upstream must honour full.
//  - Pop: issue_i & issue_ok_o -> pop 2 if issue_mode_i==1 & issue_dual_ok_o, else pop 1;
//    head += popped. issue_i with count==0 is a no-op.
//  - Simultaneous push+pop: count_next = count + pushed - popped; storage writes never hit
//    live entries by the guard above.
//  - Latency: combinational read of head/head+1; a pushed entry is visible on outputs the cycle
//    after push (no write-to-read bypass). Queue empty + push -> issue_ok_o high 1 cycle later.
//  - Wrap-around: tail/head at DEPTH-1 with +2 wrap to 1; head+1 read also wraps.
//  - buffer_full_o and issue_*ok_o derived combinationally from registered count.
// CONFIGURATION
//  INST_QUEUE_DS_KEEP_EN defined: adds input keep_ds_i (1 bit). flush & keep_ds_i -> the oldest
//   entry not popped this cycle (branch delay slot) is retained as the sole entry (head points
//   to it, count=1); if no such entry exists the queue empties. Same-cycle push dropped.
//  Undefined: port absent; flush always empties the queue.
// STRUCTURE
//  - defines.vh: `SingleIssue/`DualIssue encodings, `INST_QUEUE_DEPTH default.
//  - Sub-module inst_queue_ram: DEPTH x 64-bit, 2 write ports (we/addr/data), 2 async read
//    ports; write port 2 never targets port-1 address in same cycle. Pointer/count logic in top.
// TESTING
//  1. Reset, push {0x24010001@0xBFC00000, 0x24020002@0xBFC00004} -> next cycle issue_ok_o=1,
//     issue_dual_ok_o=1, inst1/pc1=0x24010001/0xBFC00000, inst2/pc2=0x24020002/0xBFC00004.
//  2. Two entries, issue_i=1 mode=0 -> count 1, head PC 0xBFC00004; mode=1 next cycle -> empty,
//     all outputs 0.
//  3. Push 2/cycle with no pops from empty -> buffer_full_o rises when count=28; push at
//     count=31 with 2 valid dropped, count stays 31.
//  4. Fill to wrap: head=30,count=2, push 2 + dual pop same cycle -> tail wraps 0->2,
//     outputs read entries 0,1 next cycle, count=2.
//  5. count=6, flush with push and pop asserted -> next cycle count=0, issue_ok_o=0; with
//     INST_QUEUE_DS_KEEP_EN and keep_ds_i=1 + single pop -> count=1, pc1 = old head+4.
//  6. Only push_valid2_i=1 (0x00000000@0x80000008) -> written at tail, count+=1, pc1=0x80000008.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared types and default sizing for the IF->ID instruction queue.
// Optional delay-slot retention on flush is enabled by INST_QUEUE_DS_KEEP_EN.
package inst_queue_pkg;

  localparam int IQ_DEPTH       = 32;
  localparam int IQ_AW          = 5;
  localparam int IQ_FULL_MARGIN = 4;

  typedef enum logic {
    SINGLE_ISSUE = 1'b0,
    DUAL_ISSUE   = 1'b1
  } issue_mode_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue_ram.sv
// Instruction queue storage: two synchronous write ports, two asynchronous read ports.
// The two write ports never target the same address in one cycle.
module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int AW    = IQ_AW
) (
  input  logic            clk,
  input  logic            we1_i,
  input  logic [AW-1:0]   waddr1_i,
  input  iq_entry_t       wdata1_i,
  input  logic            we2_i,
  input  logic [AW-1:0]   waddr2_i,
  input  iq_entry_t       wdata2_i,
  input  logic [AW-1:0]   raddr1_i,
  output iq_entry_t       rdata1_o,
  input  logic [AW-1:0]   raddr2_i,
  output iq_entry_t       rdata2_o
);

  iq_entry_t mem_q [DEPTH];

  // NOTE: storage has no reset; the queue count masks every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    if (we2_i) mem_q[waddr2_i] <= wdata2_i;
  end

  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/inst_queue.sv
// Dual-write / dual-read circular instruction queue between fetch and decode.
// Define INST_QUEUE_DS_KEEP_EN to add keep_ds_i (retain the delay-slot entry on flush).
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH       = IQ_DEPTH,
  parameter int AW          = IQ_AW,
  parameter int FULL_MARGIN = IQ_FULL_MARGIN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
`ifdef INST_QUEUE_DS_KEEP_EN
  input  logic        keep_ds_i,
`endif
  input  logic [31:0] push_inst1_i,
  input  logic [31:0] push_inst2_i,
  input  logic [31:0] push_pc1_i,
  input  logic [31:0] push_pc2_i,
  input  logic        push_valid1_i,
  input  logic        push_valid2_i,
  input  logic        issue_i,
  input  logic        issue_mode_i,
  output logic [31:0] issue_inst1_o,
  output logic [31:0] issue_inst2_o,
  output logic [31:0] issue_pc1_o,
  output logic [31:0] issue_pc2_o,
  output logic        issue_ok_o,
  output logic        issue_dual_ok_o,
  output logic        buffer_full_o
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    push_n, pushed_n, pop_n;
  logic [AW+1:0] fill_sum;
  logic          push_ok, we1, we2;
  iq_entry_t     wdata1, wdata2, rdata1, rdata2;

  assign issue_ok_o      = (count_q != '0);
  assign issue_dual_ok_o = (count_q > CNT_ONE);
  assign buffer_full_o   = (((AW+1)'(DEPTH) - count_q) <= (AW+1)'(FULL_MARGIN));

  // NOTE: every variable is defaulted before any branch so no latch can be inferred.
  always_comb begin
    push_n   = 2'(push_valid1_i) + 2'(push_valid2_i);
    fill_sum = (AW+2)'(count_q) + (AW+2)'(push_n);
    // Pops in the same cycle are not credited, so writes never land on a live entry.
    push_ok  = (fill_sum <= (AW+2)'(DEPTH)) && !flush && !rst;
    pushed_n = push_ok ? push_n : 2'd0;

    we1    = push_ok && (push_valid1_i || push_valid2_i);
    we2    = push_ok && push_valid1_i && push_valid2_i;
    wdata1 = push_valid1_i ? '{inst: push_inst1_i, pc: push_pc1_i}
                           : '{inst: push_inst2_i, pc: push_pc2_i};
    wdata2 = '{inst: push_inst2_i, pc: push_pc2_i};

    pop_n = 2'd0;
    if (issue_i && issue_ok_o) begin
      pop_n = (issue_mode_e'(issue_mode_i) == DUAL_ISSUE && issue_dual_ok_o) ? 2'd2 : 2'd1;
    end

    head_d  = head_q + AW'(pop_n);
    tail_d  = tail_q + AW'(pushed_n);
    count_d = count_q + (AW+1)'(pushed_n) - (AW+1)'(pop_n);

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
`ifdef INST_QUEUE_DS_KEEP_EN
      if (keep_ds_i && (count_q > (AW+1)'(pop_n))) begin
        head_d  = head_q + AW'(pop_n);
        tail_d  = head_q + AW'(pop_n) + PTR_ONE;
        count_d = CNT_ONE;
      end
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  inst_queue_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk      (clk),
    .we1_i    (we1),
    .waddr1_i (tail_q),
    .wdata1_i (wdata1),
    .we2_i    (we2),
    .waddr2_i (tail_q + PTR_ONE),
    .wdata2_i (wdata2),
    .raddr1_i (head_q),
    .rdata1_o (rdata1),
    .raddr2_i (head_q + PTR_ONE),
    .rdata2_o (rdata2)
  );

  assign issue_inst1_o = issue_ok_o      ? rdata1.inst : '0;
  assign issue_pc1_o   = issue_ok_o      ? rdata1.pc   : '0;
  assign issue_inst2_o = issue_dual_ok_o ? rdata2.inst : '0;
  assign issue_pc2_o   = issue_dual_ok_o ? rdata2.pc   : '0;

endmodule
